// File: rtl/init_pkg.sv
// Shared types for the memory initialiser: fill pattern select and FSM states.
package init_pkg;

    typedef enum logic [1:0] {MODE_ID, MODE_REV, MODE_CONST, MODE_XOR} fill_mode_t;

    typedef enum {IDLE, FILL, DONE} fill_state_t;

endpackage

// File: rtl/init_fill_if.sv
// Start handshake plus single-port RAM write bus between a controller and init_fill.
interface init_fill_if import init_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic              en;
    logic              rdy;
    fill_mode_t        mode;
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              done;

    modport master (
        output en, mode, fill_val,
        input  rdy, addr, wrdata, wren, done
    );

    modport slave (
        input  en, mode, fill_val,
        output rdy, addr, wrdata, wren, done
    );

endinterface

// File: rtl/init_fill_pattern.sv
// Combinational fill-word generator: maps a write index to its pattern word.
module init_pattern import init_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic [ADDR_W-1:0] idx,
    input  fill_mode_t        mode,
    input  logic [DATA_W-1:0] fill_val,
    output logic [DATA_W-1:0] word
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] idx_w;
    logic [DATA_W-1:0] rev_w;

    // Size casts zero-extend or keep the LSBs when DATA_W < ADDR_W.
    always_comb begin
        idx_w = DATA_W'(idx);
        rev_w = DATA_W'(LAST - idx);
        word  = idx_w;
        unique case (mode)
            MODE_ID:    word = idx_w;
            MODE_REV:   word = rev_w;
            MODE_CONST: word = fill_val;
            MODE_XOR:   word = idx_w ^ fill_val;
        endcase
    end

endmodule

// File: rtl/init_fill.sv
// Memory initialiser: writes DEPTH pattern words from address 0, one per clock, then pulses done.
//
// state | meaning
// IDLE  | rdy high, waiting for en
// FILL  | one RAM write per cycle, addr = cnt
// DONE  | single-cycle done pulse, addr holds DEPTH-1
module init_fill import init_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input logic        clk,
    input logic        rst_n,
    init_fill_if.slave bus
);

    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    if (DEPTH < 2 || (2 ** ADDR_W) < DEPTH) begin : g_param_err
        $error("init_fill: DEPTH must lie in 2..2**ADDR_W");
    end

    fill_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    fill_mode_t        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic              start;
    logic              rdy_nxt, wren_nxt, done_nxt;
    fill_mode_t        pat_mode;
    logic [DATA_W-1:0] pat_fill;
    logic [DATA_W-1:0] pat_word;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdy_nxt   = 1'b0;
        wren_nxt  = 1'b0;
        done_nxt  = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                rdy_nxt = 1'b1;
                if (bus.en) begin
                    start     = 1'b1;
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                    rdy_nxt   = 1'b0;
                    wren_nxt  = 1'b1;
                end
            end
            FILL: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    wren_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                rdy_nxt   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first word is produced on the accepting edge, before mode/fill_val are latched.
    assign pat_mode = start ? bus.mode : mode_q;
    assign pat_fill = start ? bus.fill_val : fill_q;

    init_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_pattern (
        .idx      (cnt_nxt[ADDR_W-1:0]),
        .mode     (pat_mode),
        .fill_val (pat_fill),
        .word     (pat_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mode_q     <= MODE_ID;
            fill_q     <= '0;
            bus.rdy    <= 1'b1;
            bus.wren   <= 1'b0;
            bus.done   <= 1'b0;
            bus.addr   <= '0;
            bus.wrdata <= '0;
        end else begin
            cnt      <= cnt_nxt;
            bus.rdy  <= rdy_nxt;
            bus.wren <= wren_nxt;
            bus.done <= done_nxt;
            if (start) begin
                mode_q <= bus.mode;
                fill_q <= bus.fill_val;
            end
            if (wren_nxt) begin
                bus.addr   <= cnt_nxt[ADDR_W-1:0];
                bus.wrdata <= pat_word;
            end
        end
    end

endmodule
